// File: rtl/npc_pkg.sv
// Shared types and default constants for the next-PC unit.
// NPC_EXC_EN (when defined) enables the exception entry/return path.
package npc_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'b000,
    NPC_J    = 3'b001,
    NPC_BEQ  = 3'b010,
    NPC_BNE  = 3'b011,
    NPC_JR   = 3'b100,
    NPC_BLEZ = 3'b101,
    NPC_BGTZ = 3'b110,
    NPC_BGEZ = 3'b111
  } npc_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } npc_state_e;

  localparam logic [31:0] NPC_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] NPC_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/npc_if.sv
// ID-stage / fetch-side bundle of the next-PC unit.
// Exception signals exist only when NPC_EXC_EN is defined.
interface npc_if import npc_pkg::*; #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc4_i;
  logic [15:0]     id_offset_i;
  logic [25:0]     id_index_i;
  npc_op_e         npc_op_i;
  logic [XLEN-1:0] rs_val_i;
  logic [XLEN-1:0] rt_val_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc4_o;
  logic            redirect_o;
  logic            pend_o;
`ifdef NPC_EXC_EN
  logic            exc_req_i;
  logic [XLEN-1:0] exc_pc_i;
  logic            eret_i;
  logic [XLEN-1:0] epc_o;

  modport slave (
    input  stall_i, id_valid_i, id_pc4_i, id_offset_i, id_index_i, npc_op_i,
           rs_val_i, rt_val_i, exc_req_i, exc_pc_i, eret_i,
    output pc_o, pc4_o, redirect_o, pend_o, epc_o
  );
  modport master (
    output stall_i, id_valid_i, id_pc4_i, id_offset_i, id_index_i, npc_op_i,
           rs_val_i, rt_val_i, exc_req_i, exc_pc_i, eret_i,
    input  pc_o, pc4_o, redirect_o, pend_o, epc_o
  );
`else
  modport slave (
    input  stall_i, id_valid_i, id_pc4_i, id_offset_i, id_index_i, npc_op_i,
           rs_val_i, rt_val_i,
    output pc_o, pc4_o, redirect_o, pend_o
  );
  modport master (
    output stall_i, id_valid_i, id_pc4_i, id_offset_i, id_index_i, npc_op_i,
           rs_val_i, rt_val_i,
    input  pc_o, pc4_o, redirect_o, pend_o
  );
`endif
endinterface

// File: rtl/npc_resolve.sv
// Combinational branch/jump resolver: condition evaluation and target formation.
module npc_resolve import npc_pkg::*; #(
  parameter int XLEN = 32
) (
  input  npc_op_e         op,
  input  logic            valid,
  input  logic [XLEN-1:0] pc4,
  input  logic [15:0]     offset,
  input  logic [25:0]     index,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic            taken,
  output logic [XLEN-1:0] target
);
  logic [XLEN-1:0] br_tgt, j_tgt, jr_tgt;
  logic            rs_neg, rs_zero, cond;

  assign br_tgt  = pc4 + {{(XLEN-18){offset[15]}}, offset, 2'b00};
  assign j_tgt   = {pc4[XLEN-1:28], index, 2'b00};
  assign jr_tgt  = {rs[XLEN-1:2], 2'b00};
  assign rs_neg  = rs[XLEN-1];
  assign rs_zero = (rs == '0);

  always_comb begin
    cond   = 1'b0;
    target = br_tgt;
    case (op)
      NPC_SEQ:  cond = 1'b0;
      NPC_J:    begin cond = 1'b1; target = j_tgt; end
      NPC_BEQ:  cond = (rs == rt);
      NPC_BNE:  cond = (rs != rt);
      NPC_JR:   begin cond = 1'b1; target = jr_tgt; end
      NPC_BLEZ: cond = rs_neg | rs_zero;
      NPC_BGTZ: cond = ~rs_neg & ~rs_zero;
      NPC_BGEZ: cond = ~rs_neg;
      default:  cond = 1'b0;
    endcase
  end

  assign taken = valid & cond;
endmodule

// File: rtl/npc_pc_unit.sv
// Fetch PC register + next-PC FSM; holds a redirect while IF is stalled.
// NPC_EXC_EN adds exception entry (EXC_VECTOR) and eret return via EPC.
module npc_pc_unit import npc_pkg::*; #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] RESET_PC   = NPC_RESET_PC
`ifdef NPC_EXC_EN
 ,parameter logic [31:0] EXC_VECTOR = NPC_EXC_VECTOR
`endif
) (
  input  logic  clk,
  input  logic  rst_n,
  npc_if.slave  bus
);
  localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_PC);

  npc_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_q, pend_d;
  logic            id_taken, req_taken, redirect;
  logic [XLEN-1:0] id_tgt, req_tgt;

  npc_resolve #(.XLEN(XLEN)) u_resolve (
    .op     (bus.npc_op_i),
    .valid  (bus.id_valid_i),
    .pc4    (bus.id_pc4_i),
    .offset (bus.id_offset_i),
    .index  (bus.id_index_i),
    .rs     (bus.rs_val_i),
    .rt     (bus.rt_val_i),
    .taken  (id_taken),
    .target (id_tgt)
  );

`ifdef NPC_EXC_EN
  logic [XLEN-1:0] epc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             epc_q <= '0;
    else if (bus.exc_req_i) epc_q <= bus.exc_pc_i;
  end

  assign bus.epc_o = epc_q;
  // eret outranks the ID redirect but otherwise follows the same stall rules
  assign req_taken = bus.eret_i | id_taken;
  assign req_tgt   = bus.eret_i ? epc_q : id_tgt;
`else
  assign req_taken = id_taken;
  assign req_tgt   = id_tgt;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    redirect = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req_taken) begin
          redirect = 1'b1;
          if (bus.stall_i) begin
            pend_d  = req_tgt;
            state_d = ST_PEND;
          end else begin
            pc_d = req_tgt;
          end
        end else if (!bus.stall_i) begin
          pc_d = pc_q + XLEN'(32'd4);
        end
      end
      ST_PEND: begin
        if (!bus.stall_i) begin
          pc_d    = pend_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
`ifdef NPC_EXC_EN
    // exception entry overrides stall, a pending redirect and ID
    if (bus.exc_req_i) begin
      pc_d     = XLEN'(EXC_VECTOR);
      pend_d   = '0;
      state_d  = ST_RUN;
      redirect = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RST_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc4_o      = pc_q + XLEN'(32'd4);
  assign bus.redirect_o = redirect;
  assign bus.pend_o     = (state_q == ST_PEND);
endmodule

// File: tb/tb_npc_pc_unit.sv
// Scoreboard bench for npc_pc_unit; exception path exercised when NPC_EXC_EN is defined.
module tb_npc_pc_unit;
  import npc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  npc_if #(.XLEN(32)) bus ();
  npc_pc_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input npc_op_e op, input logic vld, input logic [31:0] pc4,
                       input logic [15:0] off, input logic [25:0] idx,
                       input logic [31:0] rs, input logic [31:0] rt, input logic stall);
    bus.npc_op_i    = op;
    bus.id_valid_i  = vld;
    bus.id_pc4_i    = pc4;
    bus.id_offset_i = off;
    bus.id_index_i  = idx;
    bus.rs_val_i    = rs;
    bus.rt_val_i    = rt;
    bus.stall_i     = stall;
  endtask

  // called at a negedge with inputs already driven
  task automatic cyc(input string tag, input logic redir, input logic [31:0] pc, input logic pend);
    exp_t e;
    #1;
    chk({tag, ".redir"}, 32'(bus.redirect_o), 32'(redir));
    e.tag = tag; e.pc = pc; e.pend = pend;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      nchk++; nerr++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".pc"}, bus.pc_o, e.pc);
      chk({e.tag, ".pend"}, 32'(bus.pend_o), 32'(e.pend));
    end
    @(negedge clk);
  endtask

  initial begin
    drive(NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0);
`ifdef NPC_EXC_EN
    bus.exc_req_i = 1'b0;
    bus.exc_pc_i  = 32'h0;
    bus.eret_i    = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst.pc",   bus.pc_o, 32'h0000_3000);
    chk("rst.pc4",  bus.pc4_o, 32'h0000_3004);
    chk("rst.pend", 32'(bus.pend_o), 32'h0);
`ifdef NPC_EXC_EN
    chk("rst.epc",  bus.epc_o, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    cyc("seq1", 1'b0, 32'h0000_3004, 1'b0);
    cyc("seq2", 1'b0, 32'h0000_3008, 1'b0);
    cyc("seq3", 1'b0, 32'h0000_300C, 1'b0);

    drive(NPC_BEQ, 1'b1, 32'h3010, 16'hFFFC, 26'h0, 32'd5, 32'd5, 1'b0);
    cyc("beq_t", 1'b1, 32'h0000_3000, 1'b0);
    drive(NPC_BEQ, 1'b1, 32'h3010, 16'hFFFC, 26'h0, 32'd5, 32'd6, 1'b0);
    cyc("beq_nt", 1'b0, 32'h0000_3004, 1'b0);
    drive(NPC_BGTZ, 1'b1, 32'h3010, 16'h0001, 26'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    cyc("bgtz_nt", 1'b0, 32'h0000_3008, 1'b0);
    drive(NPC_BLEZ, 1'b1, 32'h3010, 16'h0001, 26'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    cyc("blez_t", 1'b1, 32'h0000_3014, 1'b0);
    drive(NPC_BGEZ, 1'b1, 32'h3018, 16'h0002, 26'h0, 32'h0, 32'h0, 1'b0);
    cyc("bgez_t", 1'b1, 32'h0000_3020, 1'b0);
    drive(NPC_BGEZ, 1'b1, 32'h3018, 16'h0002, 26'h0, 32'h8000_0000, 32'h0, 1'b0);
    cyc("bgez_nt", 1'b0, 32'h0000_3024, 1'b0);
    drive(NPC_J, 1'b1, 32'h3004, 16'h0, 26'h0000100, 32'h0, 32'h0, 1'b0);
    cyc("j", 1'b1, 32'h0000_0400, 1'b0);
    drive(NPC_JR, 1'b1, 32'h0404, 16'h0, 26'h0, 32'h0000_3007, 32'h0, 1'b0);
    cyc("jr", 1'b1, 32'h0000_3004, 1'b0);
    drive(NPC_BNE, 1'b0, 32'h3008, 16'h0040, 26'h0, 32'd1, 32'd2, 1'b0);
    cyc("bne_invalid", 1'b0, 32'h0000_3008, 1'b0);

    // taken branch under stall, second redirect ignored while pending
    drive(NPC_BEQ, 1'b1, 32'h30C0, 16'h0010, 26'h0, 32'd7, 32'd7, 1'b1);
    cyc("stall_br", 1'b1, 32'h0000_3008, 1'b1);
    drive(NPC_BNE, 1'b1, 32'h3000, 16'h0020, 26'h0, 32'd1, 32'd2, 1'b1);
    cyc("pend_bne", 1'b0, 32'h0000_3008, 1'b1);
    drive(NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    cyc("pend_hold", 1'b0, 32'h0000_3008, 1'b1);
    drive(NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0);
    cyc("pend_rel", 1'b0, 32'h0000_3100, 1'b0);
    drive(NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    cyc("run_stall", 1'b0, 32'h0000_3100, 1'b0);
    drive(NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0);
    cyc("run_go", 1'b0, 32'h0000_3104, 1'b0);

    drive(NPC_JR, 1'b1, 32'h3108, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    cyc("jr_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("top.pc4", bus.pc4_o, 32'h0000_0000);
    drive(NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0);
    cyc("wrap", 1'b0, 32'h0000_0000, 1'b0);

    // asynchronous reset while a redirect is pending
    drive(NPC_J, 1'b1, 32'h0004, 16'h0, 26'h0000040, 32'h0, 32'h0, 1'b1);
    cyc("pend_j", 1'b1, 32'h0000_0000, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.pc",   bus.pc_o, 32'h0000_3000);
    chk("arst.pend", 32'(bus.pend_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef NPC_EXC_EN
    drive(NPC_J, 1'b1, 32'h3004, 16'h0, 26'h0000200, 32'h0, 32'h0, 1'b1);
    cyc("exc_pre", 1'b1, 32'h0000_3000, 1'b1);
    drive(NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    bus.exc_req_i = 1'b1;
    bus.exc_pc_i  = 32'h0000_3020;
    cyc("exc", 1'b1, 32'h0000_4180, 1'b0);
    chk("exc.epc", bus.epc_o, 32'h0000_3020);
    bus.exc_req_i = 1'b0;
    bus.exc_pc_i  = 32'h0;
    drive(NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0);
    cyc("exc_seq", 1'b0, 32'h0000_4184, 1'b0);
    bus.eret_i = 1'b1;
    cyc("eret", 1'b1, 32'h0000_3020, 1'b0);
    bus.eret_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
